// File: rtl/tt_sweep_checker.sv
// Exhaustive truth-table sweeper for an N-input, 1-output combinational block.
// Each vector is held SETTLE cycles, then sampled once and compared against the selected function.
module tt_sweep_checker #(
   parameter int N      = 4,
   parameter int SETTLE = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [1:0]       mode,
   input  logic [2**N-1:0]  expected_tt,
   output logic [N-1:0]     vec,
   input  logic             dut_out,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [N:0]       err_count,
   output logic [N-1:0]     first_err,
   output logic             first_err_valid
);

   typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

   localparam logic [3:0]   CNT_INIT = 4'(SETTLE - 1);
   localparam logic [N-1:0] VEC_LAST = '1;

   state_t          state;
   logic [3:0]      cnt;
   logic [1:0]      mode_q;
   logic [2**N-1:0] tt_q;
   logic            exp_bit;
   logic            mismatch;
   logic [N:0]      err_nxt;

   // Majority means strictly more than half the inputs high, so even N needs N/2+1 ones.
   function automatic logic exp_fn(input logic [1:0] m, input logic [2**N-1:0] tt,
                                   input logic [N-1:0] v);
      int ones;
      ones = 0;
      for (int i = 0; i < N; i++) ones += int'(v[i]);
      case (m)
         2'd0:    return tt[v];
         2'd1:    return ^v;
         2'd2:    return &v;
         default: return ones > N / 2;
      endcase
   endfunction

   always_comb begin
      exp_bit  = exp_fn(mode_q, tt_q, vec);
      mismatch = (dut_out != exp_bit);
      err_nxt  = err_count + (N+1)'(mismatch);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         cnt             <= '0;
         mode_q          <= '0;
         tt_q            <= '0;
         vec             <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         pass            <= 1'b0;
         err_count       <= '0;
         first_err       <= '0;
         first_err_valid <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state           <= APPLY;
                  cnt             <= CNT_INIT;
                  mode_q          <= mode;
                  tt_q            <= expected_tt;
                  vec             <= '0;
                  busy            <= 1'b1;
                  done            <= 1'b0;
                  pass            <= 1'b0;
                  err_count       <= '0;
                  first_err       <= '0;
                  first_err_valid <= 1'b0;
               end
            end
            APPLY: begin
               if (abort) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (cnt == 4'd0) begin
                  state <= SAMPLE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            SAMPLE: begin
               // An abort here drops this cycle's sample; partial results stay visible.
               if (abort) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  err_count <= err_nxt;
                  if (mismatch && !first_err_valid) begin
                     first_err       <= vec;
                     first_err_valid <= 1'b1;
                  end
                  if (vec == VEC_LAST) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     pass  <= (err_nxt == '0);
                  end else begin
                     state <= APPLY;
                     vec   <= vec + 1'b1;
                     cnt   <= CNT_INIT;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Scoreboard bench: three checker instances (N=2/S=1, N=3/S=2, N=4/S=3) sweep small gate models;
// expected sweep results are queued at start and checked by per-instance monitors on done.
module tb_tt_sweep_checker;

   typedef struct {
      string tag;
      int    err;
      int    fe;
      bit    fev;
      bit    pass;
      int    lat;
      int    scyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // instance 2: N=2 SETTLE=1
   logic       start2 = 0, abort2 = 0, out2, busy2, done2, pass2, fev2;
   logic [1:0] mode2 = 0;
   logic [3:0] tt2 = 0;
   logic [1:0] vec2, fe2;
   logic [2:0] err2;
   bit         g2 = 0;   // 0: XOR gate, 1: tied low
   // instance 3: N=3 SETTLE=2
   logic       start3 = 0, abort3 = 0, out3, busy3, done3, pass3, fev3;
   logic [1:0] mode3 = 0;
   logic [7:0] tt3 = 0;
   logic [2:0] vec3, fe3;
   logic [3:0] err3;
   bit         g3 = 0;   // 0: majority, 1: OR gate
   // instance 4: N=4 SETTLE=3, DUT tied low
   logic        start4 = 0, abort4 = 0, out4, busy4, done4, pass4, fev4;
   logic [1:0]  mode4 = 0;
   logic [15:0] tt4 = 0;
   logic [3:0]  vec4, fe4;
   logic [4:0]  err4;

   assign out2 = g2 ? 1'b0 : (vec2[0] ^ vec2[1]);
   assign out3 = g3 ? (|vec3)
                    : ((vec3[0] & vec3[1]) | (vec3[0] & vec3[2]) | (vec3[1] & vec3[2]));
   assign out4 = 1'b0;

   tt_sweep_checker #(.N(2), .SETTLE(1)) u2 (
      .clk(clk), .rst(rst), .start(start2), .abort(abort2), .mode(mode2), .expected_tt(tt2),
      .vec(vec2), .dut_out(out2), .busy(busy2), .done(done2), .pass(pass2),
      .err_count(err2), .first_err(fe2), .first_err_valid(fev2));
   tt_sweep_checker #(.N(3), .SETTLE(2)) u3 (
      .clk(clk), .rst(rst), .start(start3), .abort(abort3), .mode(mode3), .expected_tt(tt3),
      .vec(vec3), .dut_out(out3), .busy(busy3), .done(done3), .pass(pass3),
      .err_count(err3), .first_err(fe3), .first_err_valid(fev3));
   tt_sweep_checker #(.N(4), .SETTLE(3)) u4 (
      .clk(clk), .rst(rst), .start(start4), .abort(abort4), .mode(mode4), .expected_tt(tt4),
      .vec(vec4), .dut_out(out4), .busy(busy4), .done(done4), .pass(pass4),
      .err_count(err4), .first_err(fe4), .first_err_valid(fev4));

   exp_t q2[$], q3[$], q4[$];

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, got, want);
      end
   endtask

   function automatic exp_t mk(input string tag, input int err, input int fe, input bit fev,
                               input bit pass, input int lat);
      exp_t e;
      e.tag = tag; e.err = err; e.fe = fe; e.fev = fev; e.pass = pass; e.lat = lat; e.scyc = 0;
      return e;
   endfunction

   task automatic cmp(input exp_t e, input int err, input int fe, input bit fev, input bit pass);
      chk({e.tag, " err_count"}, 64'(err), 64'(e.err));
      chk({e.tag, " first_err"}, 64'(fe), 64'(e.fe));
      chk({e.tag, " first_err_valid"}, 64'(fev), 64'(e.fev));
      chk({e.tag, " pass"}, 64'(pass), 64'(e.pass));
      chk({e.tag, " done latency"}, 64'(cyc - e.scyc), 64'(e.lat));
   endtask

   task automatic no_exp(input string nm);
      total++;
      bad++;
      $display("FAIL %s: done rose with no queued expectation", nm);
   endtask

   // Monitors: one pop per rising done.
   bit dp2 = 0, dp3 = 0, dp4 = 0;
   always @(negedge clk) begin
      if (done2 === 1'b1 && !dp2) begin
         if (q2.size() == 0) no_exp("u2");
         else cmp(q2.pop_front(), int'(err2), int'(fe2), fev2, pass2);
      end
      dp2 <= (done2 === 1'b1);
   end
   always @(negedge clk) begin
      if (done3 === 1'b1 && !dp3) begin
         if (q3.size() == 0) no_exp("u3");
         else cmp(q3.pop_front(), int'(err3), int'(fe3), fev3, pass3);
      end
      dp3 <= (done3 === 1'b1);
   end
   always @(negedge clk) begin
      if (done4 === 1'b1 && !dp4) begin
         if (q4.size() == 0) no_exp("u4");
         else cmp(q4.pop_front(), int'(err4), int'(fe4), fev4, pass4);
      end
      dp4 <= (done4 === 1'b1);
   end

   // Pulse start on one instance; the expectation is stamped with the accepting edge.
   task automatic go(input int idx, input bit push, input exp_t e);
      case (idx)
         2: start2 = 1;
         3: start3 = 1;
         default: start4 = 1;
      endcase
      @(posedge clk); #1;
      start2 = 0; start3 = 0; start4 = 0;
      e.scyc = cyc;
      if (push) begin
         case (idx)
            2: q2.push_back(e);
            3: q3.push_back(e);
            default: q4.push_back(e);
         endcase
      end
   endtask

   function automatic bit is_done(input int idx);
      case (idx)
         2: return done2 === 1'b1;
         3: return done3 === 1'b1;
         default: return done4 === 1'b1;
      endcase
   endfunction

   task automatic wait_done(input int idx, input int budget);
      int n = 0;
      while (!is_done(idx) && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      if (!is_done(idx)) begin
         total++;
         bad++;
         $display("FAIL timeout u%0d: done=0 after %0d cycles, expected 1", idx, budget);
      end
      @(negedge clk); #1;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 0;
      @(posedge clk); #1;
      chk("reset u2", {vec2, err2, fe2, fev2, busy2, done2, pass2}, 64'd0);
      chk("reset u3", {vec3, err3, fe3, fev3, busy3, done3, pass3}, 64'd0);
      chk("reset u4", {vec4, err4, fe4, fev4, busy4, done4, pass4}, 64'd0);

      // A: N=2 parity vs XOR gate; vec advances every 2 cycles.
      mode2 = 1; g2 = 0;
      go(2, 1, mk("A", 0, 0, 0, 1, 8));
      for (int k = 0; k < 4; k++) begin
         chk("A vec step", 64'(vec2), 64'(k));
         repeat (2) @(posedge clk);
         #1;
      end
      wait_done(2, 20);
      chk("A vec holds last", 64'(vec2), 64'd3);

      // B: majority via table then via mode 3.
      mode3 = 0; tt3 = 8'b1110_1000; g3 = 0;
      go(3, 1, mk("B tt", 0, 0, 0, 1, 24));
      wait_done(3, 60);
      mode3 = 3;
      go(3, 1, mk("B maj", 0, 0, 0, 1, 24));
      wait_done(3, 60);

      // C: AND expected, OR gate under test.
      mode3 = 2; g3 = 1;
      go(3, 1, mk("C", 6, 1, 1, 0, 24));
      wait_done(3, 60);

      // D: N=4 parity vs tied-low output; abort in DONE must be ignored.
      mode4 = 1;
      go(4, 1, mk("D", 8, 1, 1, 0, 64));
      wait_done(4, 150);
      abort4 = 1;
      @(posedge clk); #1;
      abort4 = 0;
      chk("D abort in DONE done", 64'(done4), 64'd1);
      chk("D abort in DONE err", 64'(err4), 64'd8);

      // E: abort in APPLY of vec=2 keeps partial results, then a clean sweep.
      mode2 = 1; g2 = 1;
      go(2, 0, mk("E0", 0, 0, 0, 0, 0));
      for (int n = 0; n < 20 && vec2 !== 2'd2; n++) begin
         @(posedge clk); #1;
      end
      chk("E reached vec 2 busy", {vec2, busy2}, {2'd2, 1'b1});
      abort2 = 1; start2 = 1;
      @(posedge clk); #1;
      abort2 = 0; start2 = 0;
      chk("E abort busy/done", {busy2, done2}, 64'd0);
      chk("E abort err_count", 64'(err2), 64'd1);
      chk("E abort first_err", {fev2, fe2}, {1'b1, 2'd1});
      chk("E abort vec holds", 64'(vec2), 64'd2);
      repeat (10) @(posedge clk);
      #1 chk("E stays idle", {busy2, done2}, 64'd0);
      g2 = 0;
      go(2, 1, mk("E clean", 0, 0, 0, 1, 8));
      wait_done(2, 20);

      // F: table and mode changed mid-sweep have no effect.
      mode3 = 0; tt3 = 8'b1110_1000; g3 = 0;
      go(3, 1, mk("F", 0, 0, 0, 1, 24));
      repeat (5) @(posedge clk);
      #1 tt3 = 8'h00; mode3 = 2;
      wait_done(3, 60);

      // G: rst mid-sweep returns to idle with everything cleared.
      mode4 = 1;
      go(4, 0, mk("G", 0, 0, 0, 0, 0));
      repeat (20) @(posedge clk);
      #1 chk("G partial err before rst", 64'(err4 != 0), 64'd1);
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      chk("G rst outputs", {vec4, err4, fe4, fev4, busy4, done4, pass4}, 64'd0);
      repeat (70) @(posedge clk);
      #1 chk("G stays idle", {busy4, done4}, 64'd0);

      chk("scoreboard drained", 64'(q2.size() + q3.size() + q4.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
